// File: rtl/blob_frame_feeder.sv
// Frame feeder: prefetches luma from the SDRAM read FIFO into a small circular
// buffer and streams one thresholded pixel per cycle to the blob counter.
module blob_frame_feeder #(
  parameter int IMG_COL    = 640,
  parameter int IMG_ROW    = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_threshold,
  output logic       o_rd_req,
  input  logic       i_rd_empty,
  input  logic [7:0] i_rd_data,
  output logic       o_blob_valid,
  output logic       o_blob_seq,
  input  logic       i_blob_request,
  input  logic       i_blob_done,
  input  logic [7:0] i_blob_count,
  output logic [7:0] o_count,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_underflow
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          OCC_W = PTR_W + 1;
  localparam logic [18:0] TOTAL = 19'(IMG_COL * IMG_ROW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_REQ,
    S_STREAM,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              rd_pending;
  logic [18:0]       req_cnt, pix_cnt;
  logic [7:0]        thr;
  logic              fifo_empty, push, pop, start_ok, last_pix, fetching, can_req;

  // A read is only issued if the returning word is guaranteed a free slot,
  // counting the one read that may still be in flight.
  always_comb begin
    fifo_empty = (occ == '0);
    push       = rd_pending;
    pop        = (state == S_STREAM) && !fifo_empty;
    start_ok   = (state == S_IDLE) && i_start;
    last_pix   = (pix_cnt == TOTAL - 19'd1);
    fetching   = (state == S_PREFILL) || (state == S_WAIT_REQ) || (state == S_STREAM);
    can_req    = fetching && !i_rd_empty && (req_cnt < TOTAL) &&
                 ((occ + OCC_W'(rd_pending)) < OCC_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_start)                      state_nxt = S_PREFILL;
      S_PREFILL:   if (occ >= OCC_W'(PREFILL))       state_nxt = S_WAIT_REQ;
      S_WAIT_REQ:  if (i_blob_request)               state_nxt = S_STREAM;
      S_STREAM:    if (last_pix)                     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_blob_done)                  state_nxt = S_RELEASE;
      S_RELEASE:   if (!i_blob_done)                 state_nxt = S_IDLE;
      default:                                       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_req     = can_req;
    o_blob_valid = (state == S_WAIT_REQ) || (state == S_STREAM) || (state == S_WAIT_DONE);
    o_blob_seq   = pop && (mem[rd_ptr] >= thr);
    o_busy       = (state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rd_data;
  end

  // Starved STREAM cycles still count as emitted pixels so the frame length is fixed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      rd_pending  <= 1'b0;
      req_cnt     <= '0;
      pix_cnt     <= '0;
      thr         <= '0;
      o_count     <= '0;
      o_done      <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= can_req;
      o_done     <= 1'b0;
      if (start_ok) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        occ         <= '0;
        req_cnt     <= '0;
        pix_cnt     <= '0;
        o_underflow <= 1'b0;
        thr         <= i_threshold;
      end else begin
        if (push)    wr_ptr  <= wr_ptr + 1'b1;
        if (pop)     rd_ptr  <= rd_ptr + 1'b1;
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
        if (can_req) req_cnt <= req_cnt + 19'd1;
        if (state == S_STREAM) begin
          pix_cnt <= pix_cnt + 19'd1;
          if (fifo_empty) o_underflow <= 1'b1;
        end
      end
      if ((state == S_WAIT_DONE) && i_blob_done) begin
        o_count <= i_blob_count;
        o_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blob_frame_feeder.sv
// Bench for blob_frame_feeder: a table of frame scenarios run against a
// queue-based model of the prefetch buffer and pixel stream (reduced frame size).
module tb_blob_frame_feeder;

  localparam int IMG_COL    = 32;
  localparam int IMG_ROW    = 8;
  localparam int TOTAL      = IMG_COL * IMG_ROW;
  localparam int FIFO_DEPTH = 16;
  localparam int PREFILL    = 8;

  logic       i_clk = 1'b0;
  logic       i_rst, i_start, i_rd_empty, i_blob_request, i_blob_done;
  logic [7:0] i_threshold, i_rd_data, i_blob_count;
  logic       o_rd_req, o_blob_valid, o_blob_seq, o_done, o_busy, o_underflow;
  logic [7:0] o_count;

  always #5 i_clk = ~i_clk;

  blob_frame_feeder #(
    .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .FIFO_DEPTH(FIFO_DEPTH), .PREFILL(PREFILL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_threshold(i_threshold),
    .o_rd_req(o_rd_req), .i_rd_empty(i_rd_empty), .i_rd_data(i_rd_data),
    .o_blob_valid(o_blob_valid), .o_blob_seq(o_blob_seq),
    .i_blob_request(i_blob_request), .i_blob_done(i_blob_done), .i_blob_count(i_blob_count),
    .o_count(o_count), .o_done(o_done), .o_busy(o_busy), .o_underflow(o_underflow)
  );

  typedef struct {
    logic [7:0] thr;
    int         mode;
    logic [7:0] bcount;
    int         req_delay;
    int         exp_uf;
    int         abort_at;
    bit         glitch;
  } frame_t;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] lum [TOTAL];
  int         q[$];
  int         req_idx, ret_idx, stream_k, max_occ, starve_left, mode;
  int         seq_err, uf_err, req_err, s_qsize;
  bit         in_stream, stream_done, starved, data_ret, req_seen, frame_active;
  bit         model_start, starve_used;
  logic [7:0] thr_m, exp_count;
  logic       s_rd_req, s_valid, s_seq, s_done, s_busy, s_uf;
  logic [7:0] s_count;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic flush_model();
    q.delete();
    req_idx = 0; stream_k = 0; in_stream = 0; stream_done = 0;
    starved = 0; data_ret = 0; req_seen = 0; starve_left = 0; starve_used = 0;
  endtask

  // Observe one cycle at the falling edge and advance the reference model.
  task automatic sample();
    bit   starve_now;
    logic exp_seq;
    @(negedge i_clk);
    s_rd_req = o_rd_req; s_valid = o_blob_valid; s_seq = o_blob_seq;
    s_done = o_done; s_busy = o_busy; s_uf = o_underflow; s_count = o_count;
    starve_now = 0;
    exp_seq = 1'b0;
    if (o_underflow !== starved) uf_err++;
    if (in_stream) begin
      if (q.size() == 0) starve_now = 1;
      else begin
        exp_seq = (lum[q[0]] >= thr_m);
        void'(q.pop_front());
      end
      stream_k++;
      if (stream_k == TOTAL) begin in_stream = 0; stream_done = 1; end
    end
    if (o_blob_seq !== exp_seq) seq_err++;
    if (starve_now) starved = 1;
    s_qsize = q.size();
    if (data_ret) begin
      q.push_back(ret_idx);
      if (q.size() > max_occ) max_occ = q.size();
    end
    req_seen = (o_rd_req === 1'b1);
    if (req_seen && (i_rd_empty || req_idx >= TOTAL)) req_err++;
    if (frame_active && !in_stream && !stream_done && o_blob_valid === 1'b1 && i_blob_request)
      in_stream = 1;
  endtask

  // Source side: return data one cycle after a request, and drive i_rd_empty.
  task automatic advance();
    @(posedge i_clk);
    #1;
    if (req_seen && req_idx < TOTAL) begin
      data_ret = 1; ret_idx = req_idx; i_rd_data = lum[req_idx]; req_idx++;
    end else begin
      data_ret = 0; i_rd_data = 8'($urandom);
    end
    if (i_rst) begin
      flush_model();
      frame_active = 0;
      exp_count = 8'd0;
    end
    if (model_start) begin
      flush_model();
      frame_active = 1;
      model_start = 0;
    end
    if (mode == 1 && in_stream && stream_k == 100 && !starve_used) begin
      starve_left = 20; starve_used = 1;
    end
    i_rd_empty = (mode == 2) ? ($urandom_range(0, 99) < 30) : (starve_left > 0);
    if (starve_left > 0) starve_left--;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic applyStimulus(input frame_t f);
    int n;
    bit glitched;
    seq_err = 0; uf_err = 0; req_err = 0; max_occ = 0; glitched = 0;
    mode = f.mode;
    for (int i = 0; i < TOTAL; i++)
      lum[i] = (f.mode == 2) ? 8'($urandom) :
               (((i % IMG_COL) >= 5 && (i % IMG_COL) <= 9) ? 8'd200 : 8'd10);
    i_start = 1; i_threshold = f.thr; thr_m = f.thr; model_start = 1;
    tick();
    checkOutput("count_before_start", s_count, exp_count);
    i_start = 0; i_threshold = 8'($urandom);
    tick();
    checkOutput("busy_after_start", s_busy, 1);
    n = 0;
    while (s_valid !== 1'b1 && n < 200) begin tick(); n++; end
    checkOutput("valid_rise_in_time", int'(n < 200), 1);
    checkOutput("prefill_level_reached", int'(s_qsize >= PREFILL), 1);
    repeat (f.req_delay) tick();
    i_blob_request = 1;
    n = 0;
    while (!stream_done && n < TOTAL + 100) begin
      tick(); n++;
      i_start = 0;
      if (f.glitch && !glitched && stream_k == TOTAL / 2) begin
        i_start = 1; i_threshold = 8'd0; glitched = 1;
      end
      if (f.abort_at >= 0 && stream_k == f.abort_at) break;
    end
    i_start = 0; i_blob_request = 0;
    if (f.abort_at >= 0) begin
      checkOutput("seq_before_abort", seq_err, 0);
      i_rst = 1; tick(); i_rst = 0; tick();
      checkOutput("abort_rd_req", s_rd_req, 0);
      checkOutput("abort_valid", s_valid, 0);
      checkOutput("abort_seq", s_seq, 0);
      checkOutput("abort_done", s_done, 0);
      checkOutput("abort_busy", s_busy, 0);
      checkOutput("abort_underflow", s_uf, 0);
      checkOutput("abort_count", s_count, 0);
      return;
    end
    checkOutput("stream_in_time", int'(stream_done), 1);
    i_blob_done = 1; i_blob_count = f.bcount;
    tick();
    checkOutput("valid_in_wait_done", s_valid, 1);
    checkOutput("done_not_early", s_done, 0);
    tick();
    checkOutput("done_pulse", s_done, 1);
    checkOutput("count_latched", s_count, f.bcount);
    checkOutput("valid_dropped_with_done", s_valid, 0);
    exp_count = f.bcount;
    i_blob_count = 8'($urandom);
    if (f.glitch) i_start = 1;
    tick();
    i_start = 0;
    checkOutput("done_one_cycle", s_done, 0);
    checkOutput("busy_in_release", s_busy, 1);
    i_blob_done = 0;
    tick();
    tick();
    checkOutput("idle_after_release", s_busy, 0);
    checkOutput("count_held", s_count, f.bcount);
    checkOutput("underflow_final", s_uf, (f.exp_uf == 2) ? int'(starved) : f.exp_uf);
    checkOutput("seq_mismatches", seq_err, 0);
    checkOutput("underflow_mismatches", uf_err, 0);
    checkOutput("rd_req_violations", req_err, 0);
    checkOutput("fifo_no_overflow", int'(max_occ <= FIFO_DEPTH), 1);
    if (f.mode == 0) checkOutput("rd_req_total", req_idx, TOTAL);
  endtask

  frame_t frames [8];

  initial begin
    frames[0] = '{8'd128, 0, 8'd5,   3,  0, -1,  1'b0};
    frames[1] = '{8'd128, 1, 8'd9,   0,  1, -1,  1'b0};
    frames[2] = '{8'd200, 0, 8'd17,  12, 0, -1,  1'b1};
    frames[3] = '{8'd128, 0, 8'd77,  2,  0, 150, 1'b0};
    frames[4] = '{8'd128, 0, 8'd42,  5,  0, -1,  1'b0};
    frames[5] = '{8'($urandom), 2, 8'd200, 4, 2, -1, 1'b0};
    frames[6] = '{8'($urandom), 2, 8'd255, 0, 2, -1, 1'b1};
    frames[7] = '{8'd10,  0, 8'd0,   1,  0, -1,  1'b0};

    i_rst = 1; i_start = 0; i_threshold = 0; i_rd_empty = 0; i_rd_data = 0;
    i_blob_request = 0; i_blob_done = 0; i_blob_count = 0;
    mode = 0; model_start = 0; frame_active = 0; exp_count = 0; thr_m = 0;
    seq_err = 0; uf_err = 0; req_err = 0;
    flush_model();
    tick();
    tick();
    checkOutput("reset_rd_req", s_rd_req, 0);
    checkOutput("reset_valid", s_valid, 0);
    checkOutput("reset_seq", s_seq, 0);
    checkOutput("reset_done", s_done, 0);
    checkOutput("reset_busy", s_busy, 0);
    checkOutput("reset_underflow", s_uf, 0);
    checkOutput("reset_count", s_count, 0);
    i_rst = 0;

    for (int i = 0; i < 8; i++) applyStimulus(frames[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
